// File: rtl/vec_pkg.sv
// Shared encodings and element-level arithmetic for the vector lane sequencer.
// Element operands are handled zero-extended to 64 bits; callers keep the low SEW bits.
package vec_pkg;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VMINU = 6'b000100;
  localparam logic [5:0] F6_VMAXU = 6'b000110;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] SEW_64 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Returns 0 for reserved codes so callers can reject them.
  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    case (vsew)
      SEW_8:   return 8;
      SEW_16:  return 16;
      SEW_32:  return 32;
      SEW_64:  return 64;
      default: return 0;
    endcase
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {F6_VADD, F6_VSUB, F6_VMINU, F6_VMAXU, F6_VAND, F6_VOR, F6_VXOR};
  endfunction

  // a is the vs1/scalar operand, b is vs2; vsub computes b - a.
  function automatic logic [63:0] elem_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [5:0] op);
    case (op)
      F6_VADD:  return b + a;
      F6_VSUB:  return b - a;
      F6_VMINU: return (a < b) ? a : b;
      F6_VMAXU: return (a < b) ? b : a;
      F6_VAND:  return a & b;
      F6_VOR:   return a | b;
      F6_VXOR:  return a ^ b;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/vec_lane_simd.sv
// One SIMD lane: splits its slice into SEW-wide elements and applies the opcode to each.
// Every element width that fits the lane is built; vsew selects the result.
module vec_lane_simd
  import vec_pkg::*;
#(
  parameter int LANE_BITS = 32
) (
  input  logic [LANE_BITS-1:0] a,
  input  logic [LANE_BITS-1:0] b,
  input  logic [5:0]           opcode,
  input  logic [1:0]           vsew,
  output logic [LANE_BITS-1:0] res
);

  logic [LANE_BITS-1:0] res_by_sew [4];

  for (genvar gs = 0; gs < 4; gs++) begin : g_sew
    localparam int S = 8 << gs;
    if (S <= LANE_BITS) begin : g_on
      logic [LANE_BITS-1:0] r_s;
      for (genvar ge = 0; ge < LANE_BITS / S; ge++) begin : g_elem
        assign r_s[ge*S +: S] = S'(elem_op(64'(a[ge*S +: S]), 64'(b[ge*S +: S]), opcode));
      end
      assign res_by_sew[gs] = r_s;
    end else begin : g_off
      assign res_by_sew[gs] = '0;
    end
  end

  assign res = res_by_sew[vsew];

endmodule

// File: rtl/vec_lane_seq.sv
// Vector ALU sequencer: runs one element-wise instruction over VLEN bits, NB_LANES
// lanes per beat, merging masked-off and tail elements from the old destination.
module vec_lane_seq
  import vec_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 5,
  parameter int NB_LANES   = 2,
  parameter int VL_W       = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [2:0]      op_type,
  input  logic [2:0]      vsew,
  input  logic [VL_W-1:0] vl,
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [31:0]     rs1,
  input  logic [4:0]      imm,
  input  logic [VLEN-1:0] vd_old,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [VLEN-1:0] vd
);

  localparam int LW     = 1 << LANE_WIDTH;
  localparam int W      = NB_LANES * LW;
  localparam int NBYTES = W / 8;
  localparam int MAXB   = VLEN / W;
  localparam int BW     = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int VIDX_W = $clog2(VLEN);

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [BW-1:0]   last_q, last_d;
  logic [5:0]      opcode_q, opcode_d;
  logic            is_vv_q, is_vv_d;
  logic [1:0]      sew_q, sew_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic            vm_q, vm_d;
  logic [VLEN-1:0] v0_q, v0_d;
  logic [VLEN-1:0] vs1_q, vs1_d;
  logic [VLEN-1:0] vs2_q, vs2_d;
  logic [63:0]     scal_q, scal_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic            illegal_q, illegal_d;

  logic            accept_bad;
  logic [BW-1:0]   accept_last;

  always_comb begin : accept_check
    int unsigned sew;
    int unsigned bits;
    int unsigned nbeats;
    sew        = sew_bits(vsew);
    bits       = 32'(vl) * sew;
    accept_bad = (vsew > SEW_64) || (sew > LW) ||
                 !(op_type inside {OPT_VV, OPT_VX, OPT_VI}) ||
                 !op_supported(opcode) || (bits > VLEN);
    nbeats     = (bits + W - 1) / W;
    if (nbeats == 0) nbeats = 1;
    accept_last = BW'(nbeats - 1);
  end

  logic [VIDX_W-1:0] beat_base;
  logic [W-1:0]      a_beat, b_beat, old_beat, res_beat, merged_beat, scal_rep;
  logic [5:0]        sew_mask;

  assign beat_base = VIDX_W'(int'(beat_q) * W);
  assign b_beat    = vs2_q[beat_base +: W];
  assign old_beat  = vd_q[beat_base +: W];
  assign a_beat    = is_vv_q ? vs1_q[beat_base +: W] : scal_rep;

  // The scalar repeats every SEW bits; SEW divides 64, so wrap the bit index mod SEW.
  always_comb begin
    sew_mask = 6'((8 << sew_q) - 1);
    scal_rep = '0;
    for (int i = 0; i < W; i++) begin
      scal_rep[i] = scal_q[6'(i) & sew_mask];
    end
  end

  for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
    vec_lane_simd #(.LANE_BITS(LW)) u_simd (
      .a      (a_beat[gi*LW +: LW]),
      .b      (b_beat[gi*LW +: LW]),
      .opcode (opcode_q),
      .vsew   (sew_q),
      .res    (res_beat[gi*LW +: LW])
    );
  end

  // SEW is at least 8, so a byte never straddles two elements.
  logic [VL_W-1:0] elem;
  logic            wr_en;

  always_comb begin
    merged_beat = old_beat;
    elem        = '0;
    wr_en       = 1'b0;
    for (int bb = 0; bb < NBYTES; bb++) begin
      elem  = VL_W'((int'(beat_q) * NBYTES + bb) >> sew_q);
      wr_en = (elem < vl_q) && (vm_q || v0_q[elem[VIDX_W-1:0]]);
      merged_beat[bb*8 +: 8] = wr_en ? res_beat[bb*8 +: 8] : old_beat[bb*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d    = last_q;
    opcode_d  = opcode_q;
    is_vv_d   = is_vv_q;
    sew_d     = sew_q;
    vl_d      = vl_q;
    vm_d      = vm_q;
    v0_d      = v0_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    scal_d    = scal_q;
    vd_d      = vd_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (accept_bad) begin
            illegal_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            beat_d   = '0;
            last_d   = accept_last;
            opcode_d = opcode;
            is_vv_d  = (op_type == OPT_VV);
            sew_d    = vsew[1:0];
            vl_d     = vl;
            vm_d     = vm;
            v0_d     = v0;
            vs1_d    = vs1;
            vs2_d    = vs2;
            scal_d   = (op_type == OPT_VX) ? {{32{rs1[31]}}, rs1} : {{59{imm[4]}}, imm};
            vd_d     = vd_old;
          end
        end
      end
      ST_RUN: begin
        vd_d[beat_base +: W] = merged_beat;
        if (beat_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      last_q    <= '0;
      opcode_q  <= '0;
      is_vv_q   <= 1'b0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      v0_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scal_q    <= '0;
      vd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      opcode_q  <= opcode_d;
      is_vv_q   <= is_vv_d;
      sew_q     <= sew_d;
      vl_q      <= vl_d;
      vm_q      <= vm_d;
      v0_q      <= v0_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      scal_q    <= scal_d;
      vd_q      <= vd_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign illegal = illegal_q;
  assign vd      = vd_q;

endmodule

// File: tb/tb_vec_lane_seq.sv
// Directed plus random instructions for vec_lane_seq, checked against an element-level model.
module tb_vec_lane_seq;

  localparam int VLEN       = 128;
  localparam int LANE_WIDTH = 5;
  localparam int NB_LANES   = 2;
  localparam int VL_W       = 8;
  localparam int W          = NB_LANES * (1 << LANE_WIDTH);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [5:0]      opcode = '0;
  logic [2:0]      op_type = '0;
  logic [2:0]      vsew = '0;
  logic [VL_W-1:0] vl = '0;
  logic            vm = 1'b1;
  logic [VLEN-1:0] v0 = '0, vs1 = '0, vs2 = '0, vd_old = '0;
  logic [31:0]     rs1 = '0;
  logic [4:0]      imm = '0;
  logic            busy, done, illegal;
  logic [VLEN-1:0] vd;

  int vectors = 0;
  int miscompares = 0;
  logic [VLEN-1:0] vd_model = '0;

  vec_lane_seq #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH), .NB_LANES(NB_LANES), .VL_W(VL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op_type(op_type),
    .vsew(vsew), .vl(vl), .vm(vm), .v0(v0), .vs1(vs1), .vs2(vs2), .rs1(rs1), .imm(imm),
    .vd_old(vd_old), .busy(busy), .done(done), .illegal(illegal), .vd(vd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [5:0] op, input logic [2:0] opt,
                                   input logic [2:0] sewc, input int vl_i);
    if (sewc > 3'd2) return 1'b0;
    if (!(opt inside {3'b001, 3'b010, 3'b100})) return 1'b0;
    if (!(op inside {6'd0, 6'd2, 6'd4, 6'd6, 6'd9, 6'd10, 6'd11})) return 1'b0;
    if (vl_i > VLEN / (8 << sewc)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [VLEN-1:0] ref_vd(input logic [5:0] op, input logic [2:0] opt,
      input logic [2:0] sewc, input int vl_i, input logic vm_i, input logic [VLEN-1:0] v0_i,
      input logic [VLEN-1:0] vs1_i, input logic [VLEN-1:0] vs2_i, input logic [31:0] rs1_i,
      input logic [4:0] imm_i, input logic [VLEN-1:0] old);
    int sew = 8 << sewc;
    longint unsigned mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 1);
    longint unsigned scal, x, y, z;
    logic [VLEN-1:0] r = old;
    scal = (opt == 3'b010) ? longint'(signed'(rs1_i)) : longint'(signed'(imm_i));
    for (int e = 0; e < VLEN / sew; e++) begin
      y = 64'((vs2_i >> (e * sew))) & mask;
      x = (opt == 3'b001) ? (64'((vs1_i >> (e * sew))) & mask) : (scal & mask);
      case (op)
        6'd0:    z = y + x;
        6'd2:    z = y - x;
        6'd4:    z = (x < y) ? x : y;
        6'd6:    z = (x < y) ? y : x;
        6'd9:    z = x & y;
        6'd10:   z = x | y;
        6'd11:   z = x ^ y;
        default: z = 0;
      endcase
      z = z & mask;
      if (e < vl_i && (vm_i || v0_i[e])) begin
        for (int b = 0; b < sew; b++) r[e*sew + b] = z[b];
      end
    end
    return r;
  endfunction

  // Called just after a rising edge with the DUT idle; returns the vd seen at done.
  task automatic run(input string tag, input logic [5:0] op, input logic [2:0] opt,
      input logic [2:0] sewc, input int vl_i, input logic vm_i, input logic [VLEN-1:0] v0_i,
      input logic [VLEN-1:0] vs1_i, input logic [VLEN-1:0] vs2_i, input logic [31:0] rs1_i,
      input logic [4:0] imm_i, input logic [VLEN-1:0] old, input bit hold,
      output logic [VLEN-1:0] got);
    bit legal;
    logic [VLEN-1:0] exp_vd;
    int exp_b, cnt, guard;
    legal  = ref_legal(op, opt, sewc, vl_i);
    exp_vd = ref_vd(op, opt, sewc, vl_i, vm_i, v0_i, vs1_i, vs2_i, rs1_i, imm_i, old);
    exp_b  = (vl_i * (8 << sewc) + W - 1) / W;
    if (exp_b == 0) exp_b = 1;
    opcode = op; op_type = opt; vsew = sewc; vl = VL_W'(vl_i); vm = vm_i; v0 = v0_i;
    vs1 = vs1_i; vs2 = vs2_i; rs1 = rs1_i; imm = imm_i; vd_old = old; start = 1'b1;
    @(posedge clk); #1;
    got = vd;
    if (!legal) begin
      start = 1'b0;
      check({tag, " illegal pulse"}, VLEN'(illegal), VLEN'(1));
      check({tag, " illegal busy"}, VLEN'(busy), '0);
      check({tag, " illegal vd"}, vd, vd_model);
      @(posedge clk); #1;
      check({tag, " illegal clear"}, VLEN'(illegal), '0);
      return;
    end
    if (hold) begin
      opcode = 6'b001011; vs1 = ~vs1_i; vs2 = {$urandom, $urandom, $urandom, $urandom};
      vd_old = ~old; vl = 8'd1;
    end else begin
      start = 1'b0;
    end
    cnt = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) cnt++;
      @(posedge clk); #1;
      guard++;
    end
    if (done && busy) cnt++;
    start = 1'b0;
    got = vd;
    check({tag, " done seen"}, VLEN'(done), VLEN'(1));
    check({tag, " busy cycles"}, VLEN'(cnt), VLEN'(exp_b + 1));
    check({tag, " vd"}, vd, exp_vd);
    vd_model = exp_vd;
    @(posedge clk); #1;
    check({tag, " back idle"}, VLEN'({done, busy}), '0);
  endtask

  localparam logic [VLEN-1:0] VS1_A = 128'habcdabcdbeefbeef1234567887654321;
  localparam logic [VLEN-1:0] VS2_A = 128'h8765432112345678beefbeefabcdabcd;

  initial begin
    logic [VLEN-1:0] got;
    logic [5:0] ops [7] = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd9, 6'd10, 6'd11};
    int guard;

    repeat (3) @(posedge clk);
    #1;
    check("reset state", VLEN'({busy, done, illegal}), '0);
    check("reset vd", vd, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("vxor", 6'b001011, 3'b001, 3'b010, 4, 1'b1, '0, VS1_A, VS2_A, '0, '0, '0, 1'b0, got);
    check("vxor const", got, 128'h2ca8e8ecacdbe897acdbe8972ca8e8ec);

    run("vadd vx", 6'b000000, 3'b010, 3'b000, 3, 1'b1, '0, '0, VS2_A, 32'hFFFFFFFF, '0, '0,
        1'b0, got);
    check("vadd vx const", got, 128'h00ccaacc);

    run("vand masked", 6'b001001, 3'b001, 3'b010, 4, 1'b0, 128'h5, VS1_A, VS2_A, '0, '0, '1,
        1'b0, got);
    check("vand masked const", got, 128'hffffffff12241668ffffffff83450301);

    run("vi vl0", 6'b000000, 3'b100, 3'b001, 0, 1'b1, '0, VS1_A, VS2_A, '0, 5'b01111,
        128'h0123456789abcdef0011223344556677, 1'b0, got);
    check("vi vl0 const", got, 128'h0123456789abcdef0011223344556677);

    run("sew64 illegal", 6'b000000, 3'b001, 3'b011, 1, 1'b1, '0, VS1_A, VS2_A, '0, '0, '1,
        1'b0, got);

    run("start during run", 6'b000010, 3'b001, 3'b001, 8, 1'b1, '0, VS1_A, VS2_A, '0, '0,
        '0, 1'b1, got);

    run("vminu", 6'b000100, 3'b001, 3'b000, 16, 1'b1, '0, {8{16'h7f80}}, {8{16'h807f}}, '0,
        '0, '0, 1'b0, got);
    check("vminu const", got, {16{8'h7f}});
    run("vmaxu", 6'b000110, 3'b001, 3'b000, 16, 1'b1, '0, {8{16'h7f80}}, {8{16'h807f}}, '0,
        '0, '0, 1'b0, got);
    check("vmaxu const", got, {16{8'h80}});

    // Abort in the second RUN cycle; reset must clear the outputs without a clock edge.
    opcode = 6'b000000; op_type = 3'b001; vsew = 3'b010; vl = 8'd4; vm = 1'b1;
    vs1 = VS1_A; vs2 = VS2_A; vd_old = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort outputs", VLEN'({busy, done, illegal}), '0);
    check("abort vd", vd, '0);
    vd_model = '0;
    guard = 0;
    while (!(clk === 1'b1) && guard < 20) begin #1; guard++; end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort no done", VLEN'(done), '0);
    run("after abort", 6'b001010, 3'b010, 3'b001, 5, 1'b0, 128'h1b, VS1_A, VS2_A,
        32'h0000_1234, '0, '1, 1'b0, got);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [2:0] opt, sewc;
      int maxvl, vl_i;
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0:       opt = 3'($urandom_range(0, 7));
        1, 2, 3: opt = 3'b010;
        4, 5:    opt = 3'b100;
        default: opt = 3'b001;
      endcase
      sewc  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      maxvl = (sewc <= 3'd3) ? VLEN / (8 << sewc) : 16;
      vl_i  = ($urandom_range(0, 9) == 0) ? maxvl + 1 : int'($urandom_range(0, maxvl));
      run($sformatf("rand%0d", n), op, opt, sewc, vl_i, 1'($urandom_range(0, 1)),
          {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, $urandom, 5'($urandom),
          {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_lane_seq.md
Name: vec_lane_seq

Overview:
- Multi-lane vector ALU sequencer: executes one element-wise integer vector instruction over a full VLEN register.
- Spreads the work across NB_LANES parallel SIMD lanes and issues one beat per cycle.
- Supports vl (active element count), v0 masking and tail/mask-undisturbed merging with the old destination value.
- Sits between the vector decode stage and the vector register file. It replaces per-lane run/done/reg_index bookkeeping with a single start/busy/done handshake.

Parameters:
- VLEN, 128, vector register width in bits (power of 2, ≥ 64).
- LANE_WIDTH, 5, log2 of lane datapath width (5 → 32-bit lanes; legal 3..6).
- NB_LANES, 2, number of parallel lanes (power of 2, 1..8).
- VL_W, $clog2(VLEN)+1, width of the vl port.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcode  in  6  funct6.
- op_type  in  3  one-hot operand source: 001 VV, 010 VX, 100 VI.
- vsew  in  3  element width code: 000=8, 001=16, 010=32, 011=64.
- vl  in  VL_W  active element count.
- vm  in  1  1 = unmasked; 0 = use v0.
- v0  in  VLEN  mask register; bit i controls element i.
- vs1  in  VLEN  operand 1, VV mode.
- vs2  in  VLEN  operand 2.
- rs1  in  32  scalar operand, VX mode.
- imm  in  5  immediate, VI mode.
- vd_old  in  VLEN  prior destination contents.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle pulse; vd valid.
- illegal  out  1  one-cycle pulse; instruction rejected.
- vd  out  VLEN  result register.

Behaviour:
- Reset (async): state=IDLE; busy, done and illegal all 0; vd=0; all internal latches cleared. Reset asserted mid-RUN aborts immediately and produces no done.
- States:
  - IDLE → RUN on an accepted, legal start.
  - RUN → DONE when the beat counter reaches B-1.
  - DONE → IDLE unconditionally.
- busy=1 in RUN and DONE. done=1 only in DONE.
- Accept: start=1 while IDLE. At that edge, latch opcode, op_type, vsew, vl, vm, v0, vs1, vs2, rs1, imm and vd_old; load vd←vd_old. start while busy is ignored, not queued.
- Illegal (evaluated at accept):
  - SEW > 2^LANE_WIDTH;
  - vsew > 011;
  - op_type not one-hot;
  - opcode not supported;
  - vl > VLEN/SEW.
  - Response: illegal pulses for one cycle, state stays IDLE, vd unchanged.
- Supported opcodes:
  - 000000 vadd, 000010 vsub, 000100 vminu, 000110 vmaxu;
  - 001001 vand, 001010 vor, 001011 vxor.
- Scalar operand:
  - VX uses rs1 truncated to SEW (sign-extended when SEW=64 > 32).
  - VI uses imm sign-extended to SEW.
  - The scalar operand is replicated into every element.
- Beat geometry: beat width W = NB_LANES·2^LANE_WIDTH bits. Beat k covers bits [k·W +: W]. Lane j handles sub-slice [k·W + j·2^LANE_WIDTH +: 2^LANE_WIDTH] and performs 2^LANE_WIDTH/SEW SIMD ops. Carries never cross element boundaries.
- Beat count: B = max(1, ceil(vl·SEW / W)).
  - vl=0: one RUN cycle, no element written, vd = vd_old.
- Write rule for element i in the beat: write the result iff i < vl AND (vm=1 OR v0[i]=1). Otherwise the old value is kept (tail- and mask-undisturbed).
- Latency: done rises B+1 cycles after the accepting edge. A new start is accepted in the cycle after done.
- Arithmetic is modulo 2^SEW. vminu/vmaxu compare unsigned.

Decomposition:
- Package vec_pkg:
  - funct6 constants;
  - op_type encodings VV/VX/VI;
  - vsew codes;
  - state enum;
  - function sew_bits(vsew).
- Sub-module vec_lane_simd: combinational, one instance per lane. Inputs: lane slice of a, lane slice of b, opcode, vsew. Output: result slice. Instantiated NB_LANES times via generate.
- The sequencer owns the FSM, beat counter, operand latches and merge/mask logic.

Test Plan:
- VV vxor, vsew=010, vl=4, vm=1, vs1=abcdabcdbeefbeef1234567887654321, vs2=8765432112345678beefbeefabcdabcd → after 2 beats, done pulse with vd=2ca8e8ecacdbe897acdbe8972ca8e8ec, busy high exactly 3 cycles.
- VX vadd, vsew=000, rs1=FFFFFFFF, vl=3, vd_old=0, same vs2 → B=1, vd=000000000000000000000000000ccaacc.
- VV vand, vsew=010, vm=0, v0=…0101, vd_old=all-F, vl=4 → elements 0 and 2 equal vs1&vs2; elements 1 and 3 stay FFFFFFFF.
- VI vadd, imm=01111, vsew=001, vl=0 → done after 1 beat, vd=vd_old; separately, vsew=011 with LANE_WIDTH=5 → illegal pulse, busy stays 0, vd unchanged.
- start re-asserted during RUN is ignored; reset asserted in beat 1 → busy, done and vd all 0 immediately; a following start then completes normally.
- vminu/vmaxu, vsew=000, vs1 bytes 80/7F vs vs2 bytes 7F/80 → vminu gives 7F/7F, vmaxu gives 80/80 (unsigned compare).
